// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges the in-order WB stage with buffered
// long-latency results, exporting a pending-destination mask for hazard detection.
module regfile_wb_arbiter #(
   parameter int WORD_LEN      = 32,
   parameter int REG_IDX_WIDTH = 5,
   parameter int ADDR_SIZE     = 32,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          pipe_we,
   input  logic [REG_IDX_WIDTH-1:0]      pipe_rd,
   input  logic [WORD_LEN-1:0]           pipe_data,
   input  logic [ADDR_SIZE-1:0]          pipe_pc,
   output logic                          pipe_stall,
   input  logic                          lu_valid,
   output logic                          lu_ready,
   input  logic [REG_IDX_WIDTH-1:0]      lu_rd,
   input  logic [WORD_LEN-1:0]           lu_data,
   input  logic [ADDR_SIZE-1:0]          lu_pc,
   output logic                          rf_we,
   output logic [REG_IDX_WIDTH-1:0]      rf_waddr,
   output logic [WORD_LEN-1:0]           rf_wdata,
   output logic [ADDR_SIZE-1:0]          rf_pc,
   output logic [(2**REG_IDX_WIDTH)-1:0] pending_mask,
   output logic                          protocol_err
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int NUM_REGS = 2**REG_IDX_WIDTH;

   logic [REG_IDX_WIDTH-1:0] rdMem_q   [FIFO_DEPTH];
   logic [WORD_LEN-1:0]      dataMem_q [FIFO_DEPTH];
   logic [ADDR_SIZE-1:0]     pcMem_q   [FIFO_DEPTH];

   logic [CNT_W-1:0]         count_q, count_d;
   logic [PTR_W-1:0]         wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]         rdPtr_q, rdPtr_d;
   logic                     rfWe_q, rfWe_d;
   logic [REG_IDX_WIDTH-1:0] rfWaddr_q, rfWaddr_d;
   logic [WORD_LEN-1:0]      rfWdata_q, rfWdata_d;
   logic [ADDR_SIZE-1:0]     rfPc_q, rfPc_d;
   logic                     protoErr_q, protoErr_d;

   logic                     fifoFull;
   logic                     push;
   logic                     pipeSel;
   logic                     popSel;
   logic [NUM_REGS-1:0]      pendingMask;
   logic [PTR_W-1:0]         slot;

   assign fifoFull   = (count_q == CNT_W'(FIFO_DEPTH));
   assign lu_ready   = !fifoFull;
   assign pipe_stall = fifoFull;

   // Results with rd==0 are acknowledged but dropped, since x0 is never written.
   assign push    = lu_valid && lu_ready && (lu_rd != '0);
   assign pipeSel = pipe_we && (pipe_rd != '0) && !pipe_stall;
   assign popSel  = !pipeSel && (count_q != '0);

   always_comb begin
      pendingMask = '0;
      slot        = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         slot = rdPtr_q + PTR_W'(i);
         if (CNT_W'(i) < count_q) begin
            pendingMask[rdMem_q[slot]] = 1'b1;
         end
      end
      pendingMask[0] = 1'b0;
   end

   assign pending_mask = pendingMask;

   always_comb begin
      count_d    = count_q;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      rfWe_d     = 1'b0;
      rfWaddr_d  = rfWaddr_q;
      rfWdata_d  = rfWdata_q;
      rfPc_d     = rfPc_q;
      protoErr_d = protoErr_q;

      if (pipeSel) begin
         rfWe_d    = 1'b1;
         rfWaddr_d = pipe_rd;
         rfWdata_d = pipe_data;
         rfPc_d    = pipe_pc;
         // A queued older write to the same register would later clobber this one.
         if (pendingMask[pipe_rd]) begin
            protoErr_d = 1'b1;
         end
      end else if (popSel) begin
         rfWe_d    = 1'b1;
         rfWaddr_d = rdMem_q[rdPtr_q];
         rfWdata_d = dataMem_q[rdPtr_q];
         rfPc_d    = pcMem_q[rdPtr_q];
         rdPtr_d   = rdPtr_q + PTR_W'(1);
      end

      if (push) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end

      if (push && !popSel) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && popSel) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_q    <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         rfWe_q     <= 1'b0;
         rfWaddr_q  <= '0;
         rfWdata_q  <= '0;
         rfPc_q     <= '0;
         protoErr_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         rfWe_q     <= rfWe_d;
         rfWaddr_q  <= rfWaddr_d;
         rfWdata_q  <= rfWdata_d;
         rfPc_q     <= rfPc_d;
         protoErr_q <= protoErr_d;
      end
   end

   // Storage needs no reset: validity is tracked entirely by count and pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         rdMem_q[wrPtr_q]   <= lu_rd;
         dataMem_q[wrPtr_q] <= lu_data;
         pcMem_q[wrPtr_q]   <= lu_pc;
      end
   end

   assign rf_we        = rfWe_q;
   assign rf_waddr     = rfWaddr_q;
   assign rf_wdata     = rfWdata_q;
   assign rf_pc        = rfPc_q;
   assign protocol_err = protoErr_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, corner-case
// sequences and randomized traffic compared against a queue-based model.
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 4;

   typedef struct {
      logic        rstn;
      logic        pwe;
      logic [4:0]  prd;
      logic [31:0] pdata;
      logic [31:0] ppc;
      logic        luv;
      logic [4:0]  lurd;
      logic [31:0] ludata;
      logic [31:0] lupc;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic        expReady;
      logic        expStall;
      logic [31:0] expMask;
      logic        expWe;
      logic [4:0]  expWaddr;
      logic [31:0] expWdata;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] pc;
   } ent_t;

   logic        clk;
   logic        rstn;
   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic [31:0] pipe_pc;
   logic        pipe_stall;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic [31:0] lu_pc;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] rf_pc;
   logic [31:0] pending_mask;
   logic        protocol_err;

   int passCount;
   int totalCount;

   ent_t        modelQ[$];
   logic        mWe;
   logic [4:0]  mWaddr;
   logic [31:0] mWdata;
   logic [31:0] mPc;
   logic        mErr;

   regfile_wb_arbiter #(
      .WORD_LEN(32), .REG_IDX_WIDTH(5), .ADDR_SIZE(32), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn),
      .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
      .pipe_stall(pipe_stall),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data), .lu_pc(lu_pc),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_pc(rf_pc),
      .pending_mask(pending_mask), .protocol_err(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t mkStim(input logic r, input logic pwe, input logic [4:0] prd,
                                    input logic [31:0] pdata, input logic [31:0] ppc,
                                    input logic luv, input logic [4:0] lurd,
                                    input logic [31:0] ludata, input logic [31:0] lupc);
      stim_t s;
      s.rstn = r; s.pwe = pwe; s.prd = prd; s.pdata = pdata; s.ppc = ppc;
      s.luv = luv; s.lurd = lurd; s.ludata = ludata; s.lupc = lupc;
      return s;
   endfunction

   function automatic stim_t idleStim();
      return mkStim(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
   endfunction

   function automatic logic [31:0] modelMask();
      logic [31:0] m;
      m = '0;
      foreach (modelQ[i]) m[modelQ[i].rd] = 1'b1;
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      totalCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Called at a falling edge; drives one cycle, checks combinational outputs before
   // the rising edge and registered outputs after it, and returns at the next falling edge.
   task automatic applyStimulus(input stim_t s, output logic rdyS, output logic stallS,
                                output logic [31:0] maskS);
      logic        mReady, mStall, pipeSel, popSel, push;
      logic [31:0] mMask;
      ent_t        head, e;
      rstn = s.rstn; pipe_we = s.pwe; pipe_rd = s.prd; pipe_data = s.pdata; pipe_pc = s.ppc;
      lu_valid = s.luv; lu_rd = s.lurd; lu_data = s.ludata; lu_pc = s.lupc;
      #1;
      mReady = (modelQ.size() < DEPTH);
      mStall = (modelQ.size() == DEPTH);
      mMask  = modelMask();
      rdyS = lu_ready; stallS = pipe_stall; maskS = pending_mask;
      checkOutput("lu_ready", {63'd0, lu_ready}, {63'd0, mReady});
      checkOutput("pipe_stall", {63'd0, pipe_stall}, {63'd0, mStall});
      checkOutput("pending_mask", {32'd0, pending_mask}, {32'd0, mMask});

      if (!s.rstn) begin
         modelQ.delete();
         mWe = 0; mWaddr = 0; mWdata = 0; mPc = 0; mErr = 0;
      end else begin
         pipeSel = s.pwe && (s.prd != 0) && !mStall;
         popSel  = !pipeSel && (modelQ.size() > 0);
         push    = s.luv && mReady && (s.lurd != 0);
         if (pipeSel) begin
            if (mMask[s.prd]) mErr = 1'b1;
            mWe = 1; mWaddr = s.prd; mWdata = s.pdata; mPc = s.ppc;
         end else if (popSel) begin
            head = modelQ.pop_front();
            mWe = 1; mWaddr = head.rd; mWdata = head.data; mPc = head.pc;
         end else begin
            mWe = 0;
         end
         if (push) begin
            e.rd = s.lurd; e.data = s.ludata; e.pc = s.lupc;
            modelQ.push_back(e);
         end
      end

      @(posedge clk);
      #1;
      checkOutput("rf_we", {63'd0, rf_we}, {63'd0, mWe});
      checkOutput("rf_waddr", {59'd0, rf_waddr}, {59'd0, mWaddr});
      checkOutput("rf_wdata", {32'd0, rf_wdata}, {32'd0, mWdata});
      checkOutput("rf_pc", {32'd0, rf_pc}, {32'd0, mPc});
      checkOutput("protocol_err", {63'd0, protocol_err}, {63'd0, mErr});
      @(negedge clk);
   endtask

   initial begin
      vec_t        vecs[7];
      logic        rdyS, stallS;
      logic [31:0] maskS;
      stim_t       s;

      passCount = 0;
      totalCount = 0;

      s = idleStim();
      rstn = 0; pipe_we = 0; pipe_rd = 0; pipe_data = 0; pipe_pc = 0;
      lu_valid = 0; lu_rd = 0; lu_data = 0; lu_pc = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      modelQ.delete();
      mWe = 0; mWaddr = 0; mWdata = 0; mPc = 0; mErr = 0;
      checkOutput("reset_rf_we", {63'd0, rf_we}, 64'd0);
      checkOutput("reset_rf_pc", {32'd0, rf_pc}, 64'd0);
      checkOutput("reset_err", {63'd0, protocol_err}, 64'd0);
      checkOutput("reset_ready", {63'd0, lu_ready}, 64'd1);
      checkOutput("reset_mask", {32'd0, pending_mask}, 64'd0);

      vecs[0] = '{mkStim(1, 1, 5'd5, 32'h1234, 32'h100, 0, 5'd0, 0, 0), 1, 0, 32'h0, 1, 5'd5, 32'h1234};
      vecs[1] = '{idleStim(),                                           1, 0, 32'h0, 0, 5'd5, 32'h1234};
      vecs[2] = '{mkStim(1, 0, 5'd0, 0, 0, 1, 5'd3, 32'hAA, 32'h200),   1, 0, 32'h0, 0, 5'd5, 32'h1234};
      vecs[3] = '{idleStim(),                                           1, 0, 32'h8, 1, 5'd3, 32'hAA};
      vecs[4] = '{idleStim(),                                           1, 0, 32'h0, 0, 5'd3, 32'hAA};
      vecs[5] = '{mkStim(1, 1, 5'd0, 32'h55, 32'h300, 1, 5'd0, 32'h66, 32'h304),
                  1, 0, 32'h0, 0, 5'd3, 32'hAA};
      vecs[6] = '{idleStim(),                                           1, 0, 32'h0, 0, 5'd3, 32'hAA};

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].s, rdyS, stallS, maskS);
         checkOutput($sformatf("vec%0d_ready", i), {63'd0, rdyS}, {63'd0, vecs[i].expReady});
         checkOutput($sformatf("vec%0d_stall", i), {63'd0, stallS}, {63'd0, vecs[i].expStall});
         checkOutput($sformatf("vec%0d_mask", i), {32'd0, maskS}, {32'd0, vecs[i].expMask});
         checkOutput($sformatf("vec%0d_we", i), {63'd0, rf_we}, {63'd0, vecs[i].expWe});
         checkOutput($sformatf("vec%0d_waddr", i), {59'd0, rf_waddr}, {59'd0, vecs[i].expWaddr});
         checkOutput($sformatf("vec%0d_wdata", i), {32'd0, rf_wdata}, {32'd0, vecs[i].expWdata});
      end

      // Fill the FIFO while the pipeline writes every cycle, then drain it.
      for (int k = 0; k < 4; k++) begin
         s = mkStim(1, 1, 5'(10 + k), 32'h1000 + k, 32'h400 + 4 * k, 1, 5'(1 + k), 32'h2000 + k, 32'h500 + 4 * k);
         applyStimulus(s, rdyS, stallS, maskS);
      end
      for (int k = 0; k < 4; k++) begin
         applyStimulus(idleStim(), rdyS, stallS, maskS);
         if (k == 0) begin
            checkOutput("full_mask", {32'd0, maskS}, 64'h1E);
            checkOutput("full_stall", {63'd0, stallS}, 64'd1);
            checkOutput("full_ready", {63'd0, rdyS}, 64'd0);
         end
         if (k == 1) checkOutput("stall_drop", {63'd0, stallS}, 64'd0);
         checkOutput($sformatf("drain%0d_waddr", k), {59'd0, rf_waddr}, 64'(k + 1));
      end
      applyStimulus(idleStim(), rdyS, stallS, maskS);

      // Keep two entries queued while pushing and popping together so pointers wrap.
      applyStimulus(mkStim(1, 0, 0, 0, 0, 1, 5'd7, 32'h700, 32'h600), rdyS, stallS, maskS);
      applyStimulus(mkStim(1, 1, 5'd20, 32'h7, 32'h604, 1, 5'd8, 32'h701, 32'h608), rdyS, stallS, maskS);
      for (int k = 0; k < 12; k++) begin
         s = mkStim(1, 0, 0, 0, 0, 1, 5'(7 + (k % 5)), 32'h710 + k, 32'h700 + 4 * k);
         applyStimulus(s, rdyS, stallS, maskS);
         checkOutput($sformatf("wrap%0d_we", k), {63'd0, rf_we}, 64'd1);
      end
      repeat (3) applyStimulus(idleStim(), rdyS, stallS, maskS);

      // WAW: queue rd=9 behind a busy pipeline, then let the pipeline write rd=9.
      applyStimulus(mkStim(1, 1, 5'd20, 32'h1, 32'h800, 1, 5'd9, 32'h99, 32'h804), rdyS, stallS, maskS);
      applyStimulus(mkStim(1, 1, 5'd9, 32'h2, 32'h808, 0, 5'd0, 0, 0), rdyS, stallS, maskS);
      checkOutput("waw_err_set", {63'd0, protocol_err}, 64'd1);
      for (int k = 0; k < 3; k++) begin
         s = mkStim(1, 1, 5'd21, 32'h3, 32'h810, 1, 5'(22 + k), 32'h30 + k, 32'h820);
         applyStimulus(s, rdyS, stallS, maskS);
      end
      checkOutput("waw_err_sticky", {63'd0, protocol_err}, 64'd1);
      s = idleStim();
      s.rstn = 1'b0;
      applyStimulus(s, rdyS, stallS, maskS);
      checkOutput("midreset_err", {63'd0, protocol_err}, 64'd0);
      checkOutput("midreset_ready", {63'd0, lu_ready}, 64'd1);
      checkOutput("midreset_mask", {32'd0, pending_mask}, 64'd0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(idleStim(), rdyS, stallS, maskS);
         checkOutput($sformatf("midreset_quiet%0d", k), {63'd0, rf_we}, 64'd0);
      end

      // Randomized traffic on a small register range to provoke hazards and full FIFOs.
      for (int n = 0; n < 400; n++) begin
         s = mkStim(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    $urandom, $urandom, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                    $urandom, $urandom);
         applyStimulus(s, rdyS, stallS, maskS);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
